// File: rtl/text_mem_arbiter_pkg.sv
// Shared types for the text memory arbiter: word address and arbitration state.
`include "config.sv"

package text_mem_arbiter_pkg;
  localparam int unsigned ADDR_W = `TEXT_BITS - 2;

  typedef logic [ADDR_W-1:0] word_addr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/config.sv
// Build-wide configuration for the text memory arbiter; guarded so repeated inclusion is harmless.
`ifndef TEXT_MEM_CONFIG_SV
`define TEXT_MEM_CONFIG_SV
`ifndef TEXT_BITS
`define TEXT_BITS 12
`endif
`endif

// File: rtl/text_mem_arbiter.sv
// Two-port (fetch / data) read arbiter in front of a single-port text memory.
// Optional fetch anti-starvation enabled by defining TEXT_ARB_FAIR_EN.
`include "config.sv"

module text_mem_arbiter
  import text_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req_valid,
  input  word_addr_t  if_req_addr,
  output logic        if_req_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  input  logic        d_req_valid,
  input  word_addr_t  d_req_addr,
  output logic        d_req_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output word_addr_t  mem_address,
  input  logic [31:0] mem_q
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e  state_q, state_d;
  word_addr_t  addr_q, addr_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] d_data_q, d_data_d;
  logic        if_win, d_win, if_acc, d_acc;

`ifdef TEXT_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

  always_comb begin
    d_win  = d_req_valid;
    if_win = if_req_valid & ~d_req_valid;
`ifdef TEXT_ARB_FAIR_EN
    if (if_req_valid && d_req_valid && (starve_cnt_q == CNT_W'(STARVE_LIMIT))) begin
      d_win  = 1'b0;
      if_win = 1'b1;
    end
`endif
  end

  assign if_req_ready = if_win & ~reset;
  assign d_req_ready  = d_win & ~reset;
  assign if_acc       = if_req_valid & if_req_ready;
  assign d_acc        = d_req_valid & d_req_ready;

  // The memory reads combinationally, so the address must reflect this cycle's winner.
  always_comb begin
    mem_address = addr_q;
    if (reset)       mem_address = '0;
    else if (if_acc) mem_address = if_req_addr;
    else if (d_acc)  mem_address = d_req_addr;
  end

  always_comb begin
    addr_d    = mem_address;
    state_d   = IDLE;
    if_data_d = if_data_q;
    d_data_d  = d_data_q;
    if (if_acc) begin
      state_d   = GNT_IF;
      if_data_d = mem_q;
    end else if (d_acc) begin
      state_d  = GNT_D;
      d_data_d = mem_q;
    end
  end

`ifdef TEXT_ARB_FAIR_EN
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || if_acc) starve_cnt_d = '0;
    else if (d_acc)              starve_cnt_d = starve_cnt_q + 1'b1;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      if_data_q <= '0;
      d_data_q  <= '0;
`ifdef TEXT_ARB_FAIR_EN
      starve_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      if_data_q <= if_data_d;
      d_data_q  <= d_data_d;
`ifdef TEXT_ARB_FAIR_EN
      starve_cnt_q <= starve_cnt_d;
`endif
    end
  end

  // Responses are gated by reset so an in-flight grant is dropped in the reset cycle.
  assign if_resp_valid = (state_q == GNT_IF) & ~reset;
  assign d_resp_valid  = (state_q == GNT_D) & ~reset;
  assign if_resp_data  = reset ? '0 : if_data_q;
  assign d_resp_data   = reset ? '0 : d_data_q;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter: vector table plus scoreboard of expected responses.
`include "config.sv"

module tb_text_mem_arbiter;
  import text_mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0;
  word_addr_t  if_req_addr = '0;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid = 1'b0;
  word_addr_t  d_req_addr = '0;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  word_addr_t  mem_address;
  logic [31:0] mem_q;

  text_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_address(mem_address), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input word_addr_t a);
    if (a == word_addr_t'(16'h10)) return 32'hDEADBEEF;
    return 32'hC0DE0000 | 32'(a) | (32'(a) << 16);
  endfunction

  assign mem_q = mem_word(mem_address);

  typedef struct {
    logic        if_v;
    logic        d_v;
    logic [31:0] data;
  } exp_resp_t;

  typedef struct {
    logic       iv;
    word_addr_t ia;
    logic       dv;
    word_addr_t da;
    logic       rdy_if;
    logic       rdy_d;
  } vec_t;

  exp_resp_t  sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [31:0] last_if_data = '0;
  logic [31:0] last_d_data = '0;
  word_addr_t  last_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input word_addr_t ia, input logic dv, input word_addr_t da,
                      input logic rst, input logic erdy_if, input logic erdy_d, input string tag);
    exp_resp_t  e;
    exp_resp_t  n;
    word_addr_t ea;
    @(posedge clock);
    #1;
    reset = rst; if_req_valid = iv; if_req_addr = ia; d_req_valid = dv; d_req_addr = da;
    @(negedge clock);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s sb_empty: got 0 entries expected 1", tag);
      e = '{1'b0, 1'b0, 32'h0};
    end else begin
      e = sb.pop_front();
    end
    if (rst) begin
      e.if_v = 1'b0; e.d_v = 1'b0;
      last_if_data = '0; last_d_data = '0; last_addr = '0;
    end
    if (e.if_v) last_if_data = e.data;
    if (e.d_v)  last_d_data = e.data;
    chk({tag, " if_resp_valid"}, 32'(if_resp_valid), 32'(e.if_v));
    chk({tag, " d_resp_valid"}, 32'(d_resp_valid), 32'(e.d_v));
    chk({tag, " if_resp_data"}, if_resp_data, last_if_data);
    chk({tag, " d_resp_data"}, d_resp_data, last_d_data);
    chk({tag, " if_req_ready"}, 32'(if_req_ready), 32'(erdy_if));
    chk({tag, " d_req_ready"}, 32'(d_req_ready), 32'(erdy_d));
    ea = rst ? '0 : erdy_if ? ia : erdy_d ? da : last_addr;
    chk({tag, " mem_address"}, 32'(mem_address), 32'(ea));
    last_addr = ea;
    n.if_v = erdy_if; n.d_v = erdy_d; n.data = mem_word(ea);
    sb.push_back(n);
  endtask

  localparam word_addr_t ONES = '1;
  localparam word_addr_t ZERO = '0;

  initial begin
    vec_t vecs[$];
    sb.push_back('{1'b0, 1'b0, 32'h0});

    step(1'b0, ZERO, 1'b0, ZERO, 1'b1, 1'b0, 1'b0, "reset0");
    step(1'b1, word_addr_t'(3), 1'b1, word_addr_t'(5), 1'b1, 1'b0, 1'b0, "reset1");

    vecs.push_back('{1'b1, word_addr_t'(16'h10), 1'b0, ZERO, 1'b1, 1'b0});
    vecs.push_back('{1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0});
    vecs.push_back('{1'b1, word_addr_t'(4), 1'b1, word_addr_t'(8), 1'b0, 1'b1});
    vecs.push_back('{1'b1, word_addr_t'(4), 1'b0, ZERO, 1'b1, 1'b0});
    vecs.push_back('{1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0});
    for (int unsigned k = 0; k < 8; k++) begin
      if (k % 2 == 0) vecs.push_back('{1'b1, word_addr_t'(k + 1), 1'b0, ZERO, 1'b1, 1'b0});
      else            vecs.push_back('{1'b0, ZERO, 1'b1, word_addr_t'(k + 40), 1'b0, 1'b1});
    end
    vecs.push_back('{1'b1, ONES, 1'b0, ZERO, 1'b1, 1'b0});
    vecs.push_back('{1'b0, ZERO, 1'b1, ZERO, 1'b0, 1'b1});
    vecs.push_back('{1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0});
    vecs.push_back('{1'b0, ZERO, 1'b1, word_addr_t'(16'h55), 1'b0, 1'b1});
    vecs.push_back('{1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0});

    foreach (vecs[i])
      step(vecs[i].iv, vecs[i].ia, vecs[i].dv, vecs[i].da, 1'b0,
           vecs[i].rdy_if, vecs[i].rdy_d, $sformatf("vec%0d", i));

    // Both ports valid continuously: fairness build lets fetch in every fifth grant.
    for (int unsigned k = 0; k < 10; k++) begin
`ifdef TEXT_ARB_FAIR_EN
      if (k % 5 == 4)
        step(1'b1, word_addr_t'(7), 1'b1, word_addr_t'(k + 100), 1'b0, 1'b1, 1'b0, $sformatf("starve%0d", k));
      else
        step(1'b1, word_addr_t'(7), 1'b1, word_addr_t'(k + 100), 1'b0, 1'b0, 1'b1, $sformatf("starve%0d", k));
`else
      step(1'b1, word_addr_t'(7), 1'b1, word_addr_t'(k + 100), 1'b0, 1'b0, 1'b1, $sformatf("starve%0d", k));
`endif
    end
    step(1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0, 1'b0, "drain");

    // Reset right after an acceptance drops the response; fetch served afterwards.
    step(1'b1, word_addr_t'(16'h20), 1'b0, ZERO, 1'b0, 1'b1, 1'b0, "pre_rst");
    step(1'b1, word_addr_t'(16'h20), 1'b1, word_addr_t'(9), 1'b1, 1'b0, 1'b0, "mid_rst0");
    step(1'b1, word_addr_t'(16'h20), 1'b0, ZERO, 1'b1, 1'b0, 1'b0, "mid_rst1");
    step(1'b1, word_addr_t'(16'h10), 1'b0, ZERO, 1'b0, 1'b1, 1'b0, "post_rst");
    step(1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0, 1'b0, "post_rst_resp");
    step(1'b0, ZERO, 1'b0, ZERO, 1'b0, 1'b0, 1'b0, "tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule

// File: doc/text_mem_arbiter.md
TEXT_MEM_ARBITER -- requirements
Module: text_mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while fetch waits (used only with TEXT_ARB_FAIR_EN).
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req_valid  input  1  fetch requester presents a word address.
REQ-005 if_req_addr  input  `TEXT_BITS-2  fetch word address.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_resp_valid  output  1  if_resp_data holds the fetch result.
REQ-008 if_resp_data  output  32  fetched word.
REQ-009 d_req_valid / d_req_addr / d_req_ready  input/input/output  1/`TEXT_BITS-2/1  data-side read requester, same semantics as fetch.
REQ-010 d_resp_valid / d_resp_data  output  1/32  data-side response.
REQ-011 mem_address  output  `TEXT_BITS-2  word address driven to the text memory.
REQ-012 mem_q  input  32  combinational read data from the text memory.

Function
REQ-013 At most one request accepted per cycle; a request is accepted when req_valid and req_ready are both 1.
REQ-014 req_ready is combinational from the current valids and arbitration state; the winner's ready=1, the loser's ready=0.
REQ-015 Default priority: data port wins when both valid; fetch wins when only fetch valid.
REQ-016 mem_address = address of the accepted request; when none is accepted, mem_address holds its previous value.
REQ-017 mem_q is captured into the winner's response register at the accepting edge; resp_valid asserts exactly one cycle after acceptance for exactly one cycle.
REQ-018 The non-accepted port's resp_valid is 0; resp_data of a port holds its last value until its next response.
REQ-019 Back-to-back acceptances are allowed every cycle; throughput one word/cycle.
REQ-020 A requester must hold valid and addr stable until ready; the arbiter does not latch unaccepted requests.
REQ-021 Responses have no backpressure; requesters consume them in the resp_valid cycle.
REQ-022 Arbitration state machine: IDLE (no grant last cycle), GNT_IF, GNT_D; next state = port accepted this cycle, else IDLE.
REQ-023 Address wrap: addresses are taken modulo 2^(`TEXT_BITS-2); no range error is signalled.

Reset
REQ-024 While reset=1: both req_ready=0, both resp_valid=0, resp_data=0, mem_address=0, state=IDLE, starvation counter=0.
REQ-025 A request presented in the cycle reset deasserts is arbitrated normally; responses in flight when reset asserts are dropped (resp_valid=0 next cycle).

Configuration
REQ-026 Macro TEXT_ARB_FAIR_EN defined: a counter (width clog2(STARVE_LIMIT+1)) increments on each data grant while if_req_valid=1, clears on any fetch grant or when if_req_valid=0; when counter=STARVE_LIMIT and both valid, fetch wins.
REQ-027 TEXT_ARB_FAIR_EN undefined: pure fixed data priority; no counter logic exists; fetch may starve indefinitely.

Structure
REQ-028 Shared package holds the state enum (IDLE, GNT_IF, GNT_D) and the word-address typedef sized `TEXT_BITS-2; the module includes config.sv.
REQ-029 No sub-module; the text memory is instantiated outside and connected via mem_address/mem_q.

Verification
REQ-030 Fetch only, addr 0x10, mem word 0xDEADBEEF -> if_req_ready=1 same cycle, if_resp_valid=1 and if_resp_data=0xDEADBEEF next cycle.
REQ-031 Both valid (if 0x4, d 0x8) -> d_req_ready=1, if_req_ready=0; next cycle d_resp_valid=1, fetch accepted that cycle if data drops valid.
REQ-032 Alternating single-port requests every cycle for 8 cycles -> 8 responses, each exactly 1 cycle after its acceptance, correct port.
REQ-033 With TEXT_ARB_FAIR_EN, STARVE_LIMIT=4, both valid continuously -> grant pattern D,D,D,D,IF repeating; without macro -> D every cycle.
REQ-034 Reset asserted the cycle after an acceptance -> no resp_valid; all outputs at reset values; post-reset fetch served normally.
REQ-035 Address all-ones then all-zeros back-to-back -> both served, mem_address follows exactly.
